// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// The datapath side (master) drives the instruction fields and ALU flags; the FSM side (slave) drives the controls.
interface multicycle_control_fsm_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [3:0]       cond;
   logic [1:0]       op;
   logic [5:0]       funct;
   logic [3:0]       alu_flags;
   logic             pc_we;
   logic             pc_src;
   logic             ir_we;
   logic             reg_we;
   logic             mem_we;
   logic             alu_src;
   logic             result_sel;
   logic [1:0]       alu_op;
   logic [3:0]       flags;
   logic             busy;
   logic             halted;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output start, cond, op, funct, alu_flags,
      input  pc_we, pc_src, ir_we, reg_we, mem_we, alu_src, result_sel,
             alu_op, flags, busy, halted, retired_cnt
   );

   modport slave (
      input  start, cond, op, funct, alu_flags,
      output pc_we, pc_src, ir_we, reg_we, mem_we, alu_src, result_sel,
             alu_op, flags, busy, halted, retired_cnt
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the ARM-subset multicycle datapath.
// Holds the NZCV register and a saturating retired-instruction counter.
module multicycle_control_fsm #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   multicycle_control_fsm_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, HALT
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   logic             cond_ok;
   logic             cmd_ok;
   logic             is_cmp;
   logic [1:0]       cmd_aop;
   logic [3:0]       cmd;
   logic             fn, fz, fc, fv;

   assign cmd             = bus.funct[4:1];
   assign is_cmp          = (cmd == 4'b1010);
   assign {fn, fz, fc, fv} = flags_q;

   always_comb begin
      cond_ok = 1'b0;
      case (bus.cond)
         4'b0000: cond_ok = fz;
         4'b0001: cond_ok = !fz;
         4'b0010: cond_ok = fc;
         4'b0011: cond_ok = !fc;
         4'b0100: cond_ok = fn;
         4'b0101: cond_ok = !fn;
         4'b0110: cond_ok = fv;
         4'b0111: cond_ok = !fv;
         4'b1000: cond_ok = fc && !fz;
         4'b1001: cond_ok = !fc || fz;
         4'b1010: cond_ok = (fn == fv);
         4'b1011: cond_ok = (fn != fv);
         4'b1100: cond_ok = !fz && (fn == fv);
         4'b1101: cond_ok = fz || (fn != fv);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      cmd_ok  = 1'b1;
      cmd_aop = '0;
      case (cmd)
         4'b0100: cmd_aop = 2'b00;
         4'b0010: cmd_aop = 2'b01;
         4'b1010: cmd_aop = 2'b01;
         4'b0000: cmd_aop = 2'b10;
         4'b1100: cmd_aop = 2'b11;
         default: cmd_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      flags_d        = flags_q;
      retire         = 1'b0;
      bus.pc_we      = 1'b0;
      bus.pc_src     = 1'b0;
      bus.ir_we      = 1'b0;
      bus.reg_we     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.alu_src    = 1'b0;
      bus.result_sel = 1'b0;
      bus.alu_op     = '0;
      bus.halted     = 1'b0;
      bus.busy       = (state_q != IDLE) && (state_q != HALT);
      case (state_q)
         IDLE:   if (bus.start) state_d = FETCH;
         FETCH: begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = DECODE;
         end
         DECODE: begin
            // A failed condition skips before the opcode is considered, halt included.
            if (!cond_ok) state_d = FETCH;
            else begin
               case (bus.op)
                  2'b11:   state_d = HALT;
                  2'b10:   state_d = BRANCH;
                  2'b01:   state_d = MEMADR;
                  default: state_d = cmd_ok ? EXEC : FETCH;
               endcase
            end
         end
         EXEC: begin
            bus.alu_src = bus.funct[5];
            bus.alu_op  = cmd_aop;
            if (bus.funct[0] || is_cmp) flags_d = bus.alu_flags;
            state_d = ALUWB;
         end
         ALUWB: begin
            bus.alu_src = bus.funct[5];
            bus.alu_op  = cmd_aop;
            bus.reg_we  = !is_cmp;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         MEMADR: begin
            bus.alu_src = 1'b1;
            state_d     = bus.funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.alu_src = 1'b1;
            state_d     = MEMWB;
         end
         MEMWB: begin
            bus.reg_we     = 1'b1;
            bus.result_sel = 1'b1;
            retire         = 1'b1;
            state_d        = FETCH;
         end
         MEMWR: begin
            bus.mem_we  = 1'b1;
            bus.alu_src = 1'b1;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         HALT:    bus.halted = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   assign retired_d       = (retire && (retired_q != '1)) ? retired_q + CNT_W'(1) : retired_q;
   assign bus.flags       = flags_q;
   assign bus.retired_cnt = retired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         flags_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
      end
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed plus randomized bench for multicycle_control_fsm against an instruction-level reference model.
// A second instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_multicycle_control_fsm;
   localparam int K_IDLE = 0, K_SKIP = 1, K_DP = 2, K_LDR = 3, K_STR = 4, K_BR = 5, K_HALT = 6;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [3:0] m_flags;
   int   m_ret;

   multicycle_control_fsm_if #(.CNT_W(16)) u_if ();
   multicycle_control_fsm_if #(.CNT_W(2))  u_if2 ();

   assign u_if2.start     = u_if.start;
   assign u_if2.cond      = u_if.cond;
   assign u_if2.op        = u_if.op;
   assign u_if2.funct     = u_if.funct;
   assign u_if2.alu_flags = u_if.alu_flags;

   multicycle_control_fsm #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(u_if.slave));
   multicycle_control_fsm #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, base;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: return (c == 4'b1110);
      endcase
      return c[0] ? ~base : base;
   endfunction

   function automatic int aop_of(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 0;
         4'b0010: return 1;
         4'b1010: return 1;
         4'b0000: return 2;
         4'b1100: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int classify(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                                   input logic [3:0] f);
      if (!cond_holds(c, f)) return K_SKIP;
      if (op == 2'b11) return K_HALT;
      if (op == 2'b10) return K_BR;
      if (op == 2'b01) return fn[0] ? K_LDR : K_STR;
      return (aop_of(fn[4:1]) < 0) ? K_SKIP : K_DP;
   endfunction

   function automatic int length_of(input int k);
      case (k)
         K_DP:    return 4;
         K_LDR:   return 5;
         K_STR:   return 4;
         K_BR:    return 3;
         K_HALT:  return 3;
         default: return 2;
      endcase
   endfunction

   // {pc_we, pc_src, ir_we, reg_we, mem_we, alu_src, result_sel, alu_op[1:0], busy, halted}
   function automatic logic [10:0] mk(input logic pw, ps, iw, rw, mw, as, rs, input int aop,
                                      input logic bz, hl);
      logic [1:0] a;
      a = 2'(aop);
      return {pw, ps, iw, rw, mw, as, rs, a, bz, hl};
   endfunction

   function automatic logic [10:0] exp_vec(input int k, input int idx, input logic [5:0] fn);
      int a;
      a = aop_of(fn[4:1]);
      if (k == K_IDLE) return '0;
      if (idx == 0) return mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      if (idx == 1) return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      case (k)
         K_HALT: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         K_BR:   return mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
         K_DP:   return mk(0, 0, 0, (idx == 3) && (fn[4:1] != 4'b1010), 0, fn[5], 0, a, 1, 0);
         K_LDR:  return (idx == 4) ? mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0)
                                   : mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
         K_STR:  return mk(0, 0, 0, 0, idx == 3, 1, 0, 0, 1, 0);
         default: return '0;
      endcase
   endfunction

   function automatic logic [10:0] got_vec();
      return {u_if.pc_we, u_if.pc_src, u_if.ir_we, u_if.reg_we, u_if.mem_we, u_if.alu_src,
              u_if.result_sel, u_if.alu_op, u_if.busy, u_if.halted};
   endfunction

   task automatic check_cycle(input int k, input int idx, input logic [5:0] fn,
                              input logic [3:0] ef, input int er);
      chk($sformatf("ctrl k%0d c%0d", k, idx), 32'(got_vec()), 32'(exp_vec(k, idx, fn)));
      chk("flags", 32'(u_if.flags), 32'(ef));
      chk("retired", 32'(u_if.retired_cnt), 32'(er));
      chk("retired_sat", 32'(u_if2.retired_cnt), 32'((er > 3) ? 3 : er));
   endtask

   // Called at a falling edge while the sequencer sits in FETCH.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] af);
      int k, len;
      logic upd;
      k   = classify(c, op, fn, m_flags);
      len = length_of(k);
      upd = (k == K_DP) && (fn[0] || fn[4:1] == 4'b1010);
      u_if.cond      = c;
      u_if.op        = op;
      u_if.funct     = fn;
      u_if.alu_flags = af;
      for (int i = 0; i < len; i++) begin
         check_cycle(k, i, fn, (upd && i == 3) ? af : m_flags, m_ret);
         if (!(k == K_HALT && i == len - 1)) @(negedge clk);
      end
      if (upd) m_flags = af;
      if (k == K_DP || k == K_LDR || k == K_STR || k == K_BR) m_ret++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_flags = '0;
      m_ret   = 0;
      check_cycle(K_IDLE, 0, '0, m_flags, m_ret);
   endtask

   task automatic do_start();
      u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
   endtask

   logic [3:0] sup_cmds [5];
   logic [3:0] rc, rcmd, raf;
   logic [1:0] rop;
   logic [5:0] rfn;

   initial begin
      checks   = 0;
      failures = 0;
      sup_cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100};
      u_if.start = 1'b0;
      u_if.cond = '0;
      u_if.op = '0;
      u_if.funct = '0;
      u_if.alu_flags = '0;
      rst = 1'b0;
      @(negedge clk);
      do_reset();

      // Idle with start low stays put.
      @(negedge clk);
      check_cycle(K_IDLE, 0, '0, m_flags, m_ret);
      do_start();

      // Five ADD-immediate instructions; S=0 so ALU flags are ignored.
      for (int i = 0; i < 5; i++) run_instr(4'hE, 2'b00, 6'b101000, 4'hF);
      // CMP sets Z, BEQ taken.
      run_instr(4'hE, 2'b00, 6'b010100, 4'b0100);
      run_instr(4'h0, 2'b10, 6'b000000, 4'h0);
      // CMP clears flags, BEQ skipped.
      run_instr(4'hE, 2'b00, 6'b010100, 4'b0000);
      run_instr(4'h0, 2'b10, 6'b000000, 4'h0);
      // LDR then STR.
      run_instr(4'hE, 2'b01, 6'b100001, 4'h0);
      run_instr(4'hE, 2'b01, 6'b100000, 4'h0);
      // Unsupported cmd, never-condition, and start pulse while busy.
      run_instr(4'hE, 2'b00, 6'b000010, 4'hF);
      u_if.start = 1'b1;
      run_instr(4'hF, 2'b00, 6'b101001, 4'hF);
      u_if.start = 1'b0;
      // SUBS with flags update, then conditional ops on the result.
      run_instr(4'hE, 2'b00, 6'b000101, 4'b1001);
      run_instr(4'hB, 2'b00, 6'b011001, 4'b0110);

      for (int i = 0; i < 150; i++) begin
         rc   = 4'($urandom_range(0, 15));
         rop  = 2'($urandom_range(0, 2));
         raf  = 4'($urandom);
         rcmd = ($urandom_range(0, 4) != 0) ? sup_cmds[$urandom_range(0, 4)] : 4'($urandom);
         rfn  = {1'($urandom), rcmd, 1'($urandom)};
         run_instr(rc, rop, rfn, raf);
      end

      // Halt, then start pulses are ignored.
      run_instr(4'hE, 2'b11, 6'b000000, 4'h0);
      for (int i = 0; i < 4; i++) begin
         u_if.start = i[0];
         @(negedge clk);
         check_cycle(K_HALT, 2, '0, m_flags, m_ret);
      end
      u_if.start = 1'b0;
      do_reset();

      // Reset in the store-write cycle drops mem_we without waiting for a clock.
      do_start();
      u_if.cond  = 4'hE;
      u_if.op    = 2'b01;
      u_if.funct = 6'b100000;
      for (int i = 0; i < 4; i++) begin
         check_cycle(K_STR, i, 6'b100000, m_flags, m_ret);
         if (i < 3) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk("mem_we_async", 32'(u_if.mem_we), 32'd0);
      check_cycle(K_IDLE, 0, '0, 4'h0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_cycle(K_IDLE, 0, '0, 4'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the ARM-subset processor datapath: PC, instruction memory, register file, ALU, data memory and result mux.
- Replaces the single-cycle combinational control unit with a Moore FSM. The FSM issues per-state write enables and mux selects, evaluates condition codes against an internal NZCV register, and counts retired instructions.
- Sits beside the datapath and is driven by the instruction-register fields and the ALU flag outputs.

Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins execution from IDLE; ignored in all other states
- cond  in  4  instr[31:28], valid from DECODE onward
- op  in  2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 halt
- funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (memory)
- alu_flags  in  4  NZCV from ALU, sampled in EXEC
- pc_we  out  1  PC write enable
- pc_src  out  1  0=PC+4, 1=branch target
- ir_we  out  1  instruction register load
- reg_we  out  1  register file write (WE3)
- mem_we  out  1  data memory write
- alu_src  out  1  0=RD2, 1=extended immediate
- result_sel  out  1  0=ALU result, 1=memory data
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- flags  out  4  current NZCV register
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- retired_cnt  out  CNT_W  instructions completed, not counting skipped ones

Behaviour:
- Reset (async, rst=1): state=IDLE, flags=0, retired_cnt=0, all enables/selects/alu_op 0. Enables drop immediately, including when rst asserts mid-instruction.
- Outputs are decoded combinationally from the registered state (Moore). Only flags and retired_cnt are extra registers.
- States and actions (unlisted outputs are 0):
  - IDLE: start=1 -> FETCH; otherwise stay.
  - FETCH: ir_we=1, pc_we=1, pc_src=0. -> DECODE.
  - DECODE: evaluate cond against flags.
    - Cond false -> FETCH (skipped; not counted).
    - op=11 -> HALT.
    - op=10 -> BRANCH.
    - op=01 -> MEMADR.
    - op=00 with supported cmd -> EXEC.
    - op=00 with unsupported cmd -> FETCH (not counted).
  - EXEC: alu_src=funct[5], alu_op from cmd. If S=1 or cmd=CMP, flags<=alu_flags at end of cycle. -> ALUWB.
  - ALUWB: alu_src and alu_op held; reg_we=1 unless cmd=CMP; result_sel=0; retire. -> FETCH.
  - MEMADR: alu_src=1, alu_op=ADD. -> MEMRD if L=1, else MEMWR.
  - MEMRD: address held. -> MEMWB.
  - MEMWB: reg_we=1, result_sel=1; retire. -> FETCH.
  - MEMWR: mem_we=1, address held; retire. -> FETCH.
  - BRANCH: pc_we=1, pc_src=1; retire. -> FETCH.
  - HALT: halted=1; exits only via rst.
- Cmd map: 0100 ADD->00, 0010 SUB->01, 1010 CMP->01, 0000 AND->10, 1100 ORR->11. All other cmds are unsupported.
- Condition truth table:
  - EQ Z, NE !Z, CS C, CC !C
  - MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL (1110) always true
  - 1111 never true
- Latency from FETCH entry: data-proc 4, LDR 5, STR 4, B 3, skipped 2 cycles.
- Flags change only in EXEC. A skipped instruction never alters flags.
- Retire: retired_cnt increments by 1 on the retire cycle and saturates at 2^CNT_W-1 (no wrap).
- start asserted while busy or halted: no effect.

Test Plan:
- Reset then start, ADD imm, cond=1110, funct=101000 -> states FETCH/DECODE/EXEC/ALUWB; reg_we=1 for exactly 1 cycle in cycle 4; alu_src=1, alu_op=00; retired_cnt=1; flags unchanged at 0.
- CMP, alu_flags=0100, then BEQ (cond=0000) -> flags=0100 after EXEC; branch asserts pc_we with pc_src=1 in its 3rd cycle. Repeat with alu_flags=0000: branch skipped in 2 cycles, retired_cnt not incremented.
- LDR (op=01, L=1) then STR (L=0) -> LDR: reg_we & result_sel=1 in cycle 5, mem_we never high. STR: mem_we=1 in cycle 4, reg_we never high. retired_cnt +2.
- op=11 -> HALT after DECODE; halted=1, busy=0; further start pulses ignored. rst -> IDLE, retired_cnt=0.
- rst asserted mid-MEMWR -> mem_we falls to 0 before the next clock edge, state=IDLE.
- CNT_W=2, 5 retired ADDs -> retired_cnt sequence 1,2,3,3,3.
